// File: rtl/risc_seq_core.sv
// Two-cycle-per-instruction sequential RISC core: FETCH latches imem[pc], EXEC
// runs the ALU/branch logic. Register file, flags and pc share one clock.
module risc_seq_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            imem_we,
  input  logic [PC_W-1:0]                 imem_waddr,
  input  logic [4+2*REG_AW+DATA_W-1:0]    imem_wdata,
  input  logic [REG_AW-1:0]               dbg_raddr,
  output logic [DATA_W-1:0]               dbg_rdata,
  output logic [PC_W-1:0]                 pc,
  output logic                            busy,
  output logic                            halted,
  output logic                            flag_z,
  output logic                            flag_c
);

  localparam int INSTR_W    = 4 + 2*REG_AW + DATA_W;
  localparam int NREGS      = 2**REG_AW;
  localparam int IMEM_DEPTH = 2**PC_W;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_BC   = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t              state_reg, state_next;
  logic [PC_W-1:0]     pc_reg, pc_next;
  logic [INSTR_W-1:0]  instr_reg;
  logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
  logic [DATA_W-1:0]   regs_reg [NREGS];
  logic                flag_z_reg, flag_z_next;
  logic                flag_c_reg, flag_c_next;
  logic                busy_reg, halted_reg;
  logic                fetch_en, reg_we, imem_wr_ok;
  logic [NREGS-1:0]    reg_sel;

  // Instruction fields
  logic [3:0]          op;
  logic [REG_AW-1:0]   rd, rs;
  logic [DATA_W-1:0]   imm, opa, opb;
  logic [PC_W-1:0]     pc_inc, target;
  logic [DATA_W:0]     sum_w, diff_w, addi_w;

  assign op     = instr_reg[INSTR_W-1 -: 4];
  assign rd     = instr_reg[INSTR_W-5 -: REG_AW];
  assign rs     = instr_reg[INSTR_W-5-REG_AW -: REG_AW];
  assign imm    = instr_reg[DATA_W-1:0];
  assign target = imm[PC_W-1:0];
  assign pc_inc = pc_reg + PC_W'(1);

  // Both operands are read before the write, so rd == rs sees the old value.
  assign opa    = regs_reg[rd];
  assign opb    = regs_reg[rs];
  assign sum_w  = {1'b0, opa} + {1'b0, opb};
  assign diff_w = {1'b0, opa} - {1'b0, opb};
  assign addi_w = {1'b0, opa} + {1'b0, imm};

  logic [DATA_W-1:0]   exe_res;
  logic                exe_c, exe_we, exe_upd_z, exe_upd_c, exe_branch, exe_halt;
  logic [PC_W-1:0]     exe_pc;

  always_comb begin
    exe_res    = '0;
    exe_c      = 1'b0;
    exe_we     = 1'b0;
    exe_upd_z  = 1'b0;
    exe_upd_c  = 1'b0;
    exe_branch = 1'b0;
    exe_halt   = 1'b0;
    case (op)
      OP_ADD:  begin exe_res = sum_w[DATA_W-1:0];  exe_c = sum_w[DATA_W];
                     exe_we = 1'b1; exe_upd_z = 1'b1; exe_upd_c = 1'b1; end
      OP_SUB:  begin exe_res = diff_w[DATA_W-1:0]; exe_c = diff_w[DATA_W];
                     exe_we = 1'b1; exe_upd_z = 1'b1; exe_upd_c = 1'b1; end
      OP_AND:  begin exe_res = opa & opb; exe_we = 1'b1; exe_upd_z = 1'b1; exe_upd_c = 1'b1; end
      OP_OR:   begin exe_res = opa | opb; exe_we = 1'b1; exe_upd_z = 1'b1; exe_upd_c = 1'b1; end
      OP_XOR:  begin exe_res = opa ^ opb; exe_we = 1'b1; exe_upd_z = 1'b1; exe_upd_c = 1'b1; end
      OP_LDI:  begin exe_res = imm; exe_we = 1'b1; end
      OP_JMP:  exe_branch = 1'b1;
      OP_HALT: exe_halt = 1'b1;
      OP_BZ:   exe_branch = flag_z_reg;
      OP_BC:   exe_branch = flag_c_reg;
      OP_MOV:  begin exe_res = opb; exe_we = 1'b1; end
      OP_ADDI: begin exe_res = addi_w[DATA_W-1:0]; exe_c = addi_w[DATA_W];
                     exe_we = 1'b1; exe_upd_z = 1'b1; exe_upd_c = 1'b1; end
      default: ;
    endcase
    if (exe_halt)
      exe_pc = pc_reg;
    else if (exe_branch)
      exe_pc = target;
    else
      exe_pc = pc_inc;
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    fetch_en    = 1'b0;
    reg_we      = 1'b0;
    flag_z_next = flag_z_reg;
    flag_c_next = flag_c_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: begin
        fetch_en   = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        reg_we  = exe_we;
        pc_next = exe_pc;
        if (exe_upd_z) flag_z_next = (exe_res == '0);
        if (exe_upd_c) flag_c_next = exe_c;
        state_next = exe_halt ? S_HALT : S_FETCH;
      end
      S_HALT: if (start) begin
        state_next = S_FETCH;
        pc_next    = '0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      instr_reg  <= '0;
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      flag_z_reg <= flag_z_next;
      flag_c_reg <= flag_c_next;
      busy_reg   <= (state_next == S_FETCH) || (state_next == S_EXEC);
      halted_reg <= (state_next == S_HALT);
      if (fetch_en) instr_reg <= imem[pc_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg_sel
      assign reg_sel[gi] = reg_we && (rd == REG_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (reg_sel[i]) regs_reg[i] <= exe_res;
    end
  end

  // Program memory keeps its contents through reset; writes only while not running.
  assign imem_wr_ok = (state_reg == S_IDLE) || (state_reg == S_HALT);

  always_ff @(posedge clk) begin
    if (imem_we && imem_wr_ok) imem[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata = regs_reg[dbg_raddr];
  assign pc        = pc_reg;
  assign busy      = busy_reg;
  assign halted    = halted_reg;
  assign flag_z    = flag_z_reg;
  assign flag_c    = flag_c_reg;

endmodule

// File: tb/tb_risc_seq_core.sv
// Directed bench for risc_seq_core: small hand-assembled programs with
// hand-computed register, flag, pc and latency results.
module tb_risc_seq_core;
  logic        clk, rst_n, start, imem_we;
  logic [3:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic [1:0]  dbg_raddr;
  logic [7:0]  dbg_rdata;
  logic [3:0]  pc;
  logic        busy, halted, flag_z, flag_c;
  int          checks = 0;
  int          errors = 0;

  risc_seq_core #(.DATA_W(8), .REG_AW(2), .PC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .pc(pc), .busy(busy), .halted(halted),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // All stimulus changes at the falling edge; the DUT samples on the rising edge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0; imem_we = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic load_basic();
    wr(4'd0, enc(4'h5, 2'd0, 2'd0, 8'd5));
    wr(4'd1, enc(4'h5, 2'd1, 2'd0, 8'd3));
    wr(4'd2, enc(4'h0, 2'd0, 2'd1, 8'd0));
    wr(4'd3, enc(4'h7, 2'd0, 2'd0, 8'd0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; dbg_raddr = '0;
    @(negedge clk);
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if ({busy, halted} !== 2'b00) begin errors++; $display("FAIL reset_busy_halted: got %b expected 00", {busy, halted}); end
    checks++; if ({flag_z, flag_c} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {flag_z, flag_c}); end
    for (int i = 0; i < 4; i++) begin
      dbg_raddr = 2'(i); #1;
      checks++; if (dbg_rdata !== 8'h00) begin errors++; $display("FAIL reset_r%0d: got %0h expected 0", i, dbg_rdata); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int cyc;
    do_reset();
    load_basic();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    run_to_halt(40, cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", cyc); end
    dbg_raddr = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'h08) begin errors++; $display("FAIL basic_r0: got %0h expected 08", dbg_rdata); end
    checks++; if ({flag_z, flag_c} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {flag_z, flag_c}); end
    checks++; if (pc !== 4'd3) begin errors++; $display("FAIL basic_pc: got %0h expected 3", pc); end
    checks++; if ({busy, halted} !== 2'b01) begin errors++; $display("FAIL basic_state: got %b expected 01", {busy, halted}); end
    $display("test_basic: cycles=%0d r0=%0h pc=%0h", cyc, dbg_rdata, pc);
  endtask

  task automatic test_carry_bc();
    int cyc;
    do_reset();
    wr(4'd0, enc(4'h5, 2'd0, 2'd0, 8'hFF));
    wr(4'd1, enc(4'h5, 2'd1, 2'd0, 8'h01));
    wr(4'd2, enc(4'h0, 2'd0, 2'd1, 8'h00));
    wr(4'd3, enc(4'h9, 2'd0, 2'd0, 8'h06));
    wr(4'd4, enc(4'h7, 2'd0, 2'd0, 8'h00));
    wr(4'd6, enc(4'h7, 2'd0, 2'd0, 8'h00));
    pulse_start();
    run_to_halt(40, cyc);
    dbg_raddr = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'h00) begin errors++; $display("FAIL carry_r0: got %0h expected 00", dbg_rdata); end
    checks++; if ({flag_z, flag_c} !== 2'b11) begin errors++; $display("FAIL carry_flags: got %b expected 11", {flag_z, flag_c}); end
    checks++; if (pc !== 4'd6) begin errors++; $display("FAIL carry_bc_pc: got %0h expected 6", pc); end
    checks++; if (cyc !== 10 || halted !== 1'b1) begin errors++; $display("FAIL carry_halt: got cycles %0d halted %b expected 10 1", cyc, halted); end
    $display("test_carry_bc: r0=%0h pc=%0h", dbg_rdata, pc);
  endtask

  task automatic test_sub_bz();
    int cyc;
    do_reset();
    wr(4'd0, enc(4'h5, 2'd0, 2'd0, 8'h02));
    wr(4'd1, enc(4'h5, 2'd1, 2'd0, 8'h03));
    wr(4'd2, enc(4'h1, 2'd0, 2'd1, 8'h00));
    wr(4'd3, enc(4'h8, 2'd0, 2'd0, 8'h07));
    wr(4'd4, enc(4'h7, 2'd0, 2'd0, 8'h00));
    wr(4'd7, enc(4'h7, 2'd0, 2'd0, 8'h00));
    pulse_start();
    run_to_halt(40, cyc);
    dbg_raddr = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'hFF) begin errors++; $display("FAIL sub_r0: got %0h expected FF", dbg_rdata); end
    checks++; if ({flag_z, flag_c} !== 2'b01) begin errors++; $display("FAIL sub_flags: got %b expected 01", {flag_z, flag_c}); end
    checks++; if (pc !== 4'd4 || cyc !== 10) begin errors++; $display("FAIL sub_bz_pc: got pc %0h cycles %0d expected 4 10", pc, cyc); end
    $display("test_sub_bz: r0=%0h pc=%0h", dbg_rdata, pc);
  endtask

  // First pass: ADDI gives 0x80 with C=0, BC falls through, JMP 15, NOP wraps
  // to 0. Second pass: ADDI overflows to 0 with C=1, BC jumps to the HALT at 3.
  task automatic test_wrap();
    int cyc;
    logic [3:0] pc6, pc8;
    do_reset();
    wr(4'd0,  enc(4'hB, 2'd3, 2'd0, 8'h80));
    wr(4'd1,  enc(4'h9, 2'd0, 2'd0, 8'h03));
    wr(4'd2,  enc(4'h6, 2'd0, 2'd0, 8'h0F));
    wr(4'd3,  enc(4'h7, 2'd0, 2'd0, 8'h00));
    wr(4'd15, enc(4'hC, 2'd0, 2'd0, 8'h00));
    pulse_start();
    cyc = 0; pc6 = 'x; pc8 = 'x;
    while (!halted && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 6) pc6 = pc;
      if (cyc == 8) pc8 = pc;
    end
    checks++; if (pc6 !== 4'd15) begin errors++; $display("FAIL wrap_jmp_pc: got %0h expected F", pc6); end
    checks++; if (pc8 !== 4'd0) begin errors++; $display("FAIL wrap_pc: got %0h expected 0", pc8); end
    checks++; if (cyc !== 14 || pc !== 4'd3) begin errors++; $display("FAIL wrap_halt: got cycles %0d pc %0h expected 14 3", cyc, pc); end
    dbg_raddr = 2'd3; #1;
    checks++; if (dbg_rdata !== 8'h00 || {flag_z, flag_c} !== 2'b11) begin errors++; $display("FAIL wrap_r3_flags: got %0h %b expected 00 11", dbg_rdata, {flag_z, flag_c}); end
    $display("test_wrap: cycles=%0d pc=%0h", cyc, pc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    load_basic();
    pulse_start();
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1 || pc !== 4'd2) begin errors++; $display("FAIL midrst_pre: got busy %b pc %0h expected 1 2", busy, pc); end
    rst_n = 1'b0; dbg_raddr = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'h00) begin errors++; $display("FAIL midrst_r0: got %0h expected 00", dbg_rdata); end
    checks++; if ({busy, halted} !== 2'b00 || pc !== 4'd0) begin errors++; $display("FAIL midrst_state: got %b pc %0h expected 00 0", {busy, halted}, pc); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || pc !== 4'd0) begin errors++; $display("FAIL midrst_noresume: got busy %b pc %0h expected 0 0", busy, pc); end
    pulse_start();
    run_to_halt(40, cyc);
    dbg_raddr = 2'd0; #1;
    checks++; if (cyc !== 8 || dbg_rdata !== 8'h08 || pc !== 4'd3) begin errors++; $display("FAIL midrst_rerun: got cycles %0d r0 %0h pc %0h expected 8 08 3", cyc, dbg_rdata, pc); end
    $display("test_reset_mid: rerun r0=%0h", dbg_rdata);
  endtask

  task automatic test_imem_guard();
    int cyc;
    do_reset();
    load_basic();
    pulse_start();
    imem_we = 1'b1; imem_waddr = 4'd2; imem_wdata = enc(4'h7, 2'd0, 2'd0, 8'h00);
    repeat (3) @(negedge clk);
    imem_we = 1'b0;
    run_to_halt(40, cyc);
    dbg_raddr = 2'd0; #1;
    checks++; if (cyc + 3 !== 8 || pc !== 4'd3) begin errors++; $display("FAIL guard_halt: got cycles %0d pc %0h expected 8 3", cyc + 3, pc); end
    checks++; if (dbg_rdata !== 8'h08) begin errors++; $display("FAIL guard_r0: got %0h expected 08", dbg_rdata); end
    pulse_start();
    run_to_halt(40, cyc);
    dbg_raddr = 2'd0; #1;
    checks++; if (cyc !== 8 || pc !== 4'd3 || dbg_rdata !== 8'h08) begin errors++; $display("FAIL guard_restart: got cycles %0d pc %0h r0 %0h expected 8 3 08", cyc, pc, dbg_rdata); end
    $display("test_imem_guard: r0=%0h", dbg_rdata);
  endtask

  task automatic test_start_write();
    int cyc;
    do_reset();
    load_basic();
    wr(4'd0, enc(4'h5, 2'd0, 2'd0, 8'd9));
    imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = enc(4'h5, 2'd0, 2'd0, 8'd5);
    start = 1'b1;
    @(negedge clk);
    imem_we = 1'b0; start = 1'b0;
    run_to_halt(40, cyc);
    dbg_raddr = 2'd0; #1;
    checks++; if (dbg_rdata !== 8'h08 || cyc !== 8) begin errors++; $display("FAIL startwr_r0: got %0h cycles %0d expected 08 8", dbg_rdata, cyc); end
    $display("test_start_write: r0=%0h", dbg_rdata);
  endtask

  task automatic test_logic();
    int cyc;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'hFC; exp_r[1] = 8'h00; exp_r[2] = 8'h30; exp_r[3] = 8'h01;
    do_reset();
    wr(4'd0,  enc(4'h5, 2'd0, 2'd0, 8'hF0));
    wr(4'd1,  enc(4'h5, 2'd1, 2'd0, 8'h3C));
    wr(4'd2,  enc(4'h5, 2'd3, 2'd0, 8'h81));
    wr(4'd3,  enc(4'h0, 2'd3, 2'd3, 8'h00));
    wr(4'd4,  enc(4'hA, 2'd2, 2'd0, 8'h00));
    wr(4'd5,  enc(4'h2, 2'd2, 2'd1, 8'h00));
    wr(4'd6,  enc(4'hB, 2'd3, 2'd0, 8'hFF));
    wr(4'd7,  enc(4'h3, 2'd0, 2'd1, 8'h00));
    wr(4'd8,  enc(4'h4, 2'd1, 2'd1, 8'h00));
    wr(4'd9,  enc(4'h8, 2'd0, 2'd0, 8'h0B));
    wr(4'd10, enc(4'h7, 2'd0, 2'd0, 8'h00));
    wr(4'd11, enc(4'h7, 2'd0, 2'd0, 8'h00));
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    run_to_halt(80, cyc);
    checks++; if (cyc + 6 !== 22 || pc !== 4'd11) begin errors++; $display("FAIL logic_halt: got cycles %0d pc %0h expected 22 B", cyc + 6, pc); end
    checks++; if ({flag_z, flag_c} !== 2'b10) begin errors++; $display("FAIL logic_flags: got %b expected 10", {flag_z, flag_c}); end
    for (int i = 0; i < 4; i++) begin
      dbg_raddr = 2'(i); #1;
      checks++; if (dbg_rdata !== exp_r[i]) begin errors++; $display("FAIL logic_r%0d: got %0h expected %0h", i, dbg_rdata, exp_r[i]); end
    end
    $display("test_logic: pc=%0h", pc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_bc();
    test_sub_bz();
    test_wrap();
    test_reset_mid();
    test_imem_guard();
    test_start_write();
    test_logic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
